// File: rtl/mdu_pkg.sv
// Shared op encodings, state enum and op-class helpers for the multiply/divide unit.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8,
      OP_MSUB  = 4'd9,
      OP_MSUBU = 4'd10
   } mdu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   function automatic logic is_signed_mul(input mdu_op_e op);
      return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the pipeline and the multiply/divide unit.
interface mul_div_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic [3:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             kill;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, a, b, kill, input busy, hi, lo);
   modport slave  (input start, op, a, b, kill, output busy, hi, lo);
endinterface

// File: rtl/mdu_div_core.sv
// Combinational signed/unsigned divider; quotient truncates toward zero,
// remainder follows the dividend sign. Flags divide-by-zero.
module mdu_div_core #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             is_signed,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b, mag_q, mag_r;

   // Magnitude form makes MIN_INT / -1 wrap to MIN_INT with a zero remainder.
   always_comb begin
      a_neg     = is_signed & dividend[WIDTH-1];
      b_neg     = is_signed & divisor[WIDTH-1];
      mag_a     = a_neg ? (~dividend + 1'b1) : dividend;
      mag_b     = b_neg ? (~divisor + 1'b1) : divisor;
      div_zero  = (divisor == '0);
      mag_q     = '0;
      mag_r     = '0;
      if (!div_zero) begin
         mag_q = mag_a / mag_b;
         mag_r = mag_a % mag_b;
      end
      quotient  = (a_neg ^ b_neg) ? (~mag_q + 1'b1) : mag_q;
      remainder = a_neg ? (~mag_r + 1'b1) : mag_r;
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit. Define MDU_MADD_EN to enable
// MADD/MADDU/MSUB/MSUBU; otherwise those opcodes are treated as no-ops.
//
// state   | meaning
// ST_IDLE | accepting ops; MTHI/MTLO write here
// ST_RUN  | mul/div in flight, busy=1, counter counting down to commit
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic          clk,
   input  logic          reset,
   mul_div_unit_if.slave bus
);

   localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int W2      = 2 * WIDTH;

   mdu_state_e       state;
   logic [CW-1:0]    cnt;
   logic             busy_r;
   logic [WIDTH-1:0] hi_r, lo_r, a_r, b_r;
   mdu_op_e          op_r;

   logic             accept, start_mul, start_div;
   logic [W2-1:0]    mul_a, mul_b, product;
   logic [WIDTH-1:0] quot, rem;
   logic             div_zero;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic             res_we;

   assign accept = (state == ST_IDLE) && bus.start && !bus.kill;

   always_comb begin
      start_mul = 1'b0;
      start_div = 1'b0;
      case (bus.op)
         OP_MULT, OP_MULTU: start_mul = 1'b1;
         OP_DIV, OP_DIVU:   start_div = 1'b1;
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: start_mul = 1'b1;
`endif
         default: ;
      endcase
   end

   // Operands come from the capture registers, so the arithmetic has the whole RUN window.
   always_comb begin
      mul_a   = is_signed_mul(op_r) ? {{WIDTH{a_r[WIDTH-1]}}, a_r} : {{WIDTH{1'b0}}, a_r};
      mul_b   = is_signed_mul(op_r) ? {{WIDTH{b_r[WIDTH-1]}}, b_r} : {{WIDTH{1'b0}}, b_r};
      product = mul_a * mul_b;
   end

   mdu_div_core #(.WIDTH(WIDTH)) u_div (
      .dividend  (a_r),
      .divisor   (b_r),
      .is_signed (op_r == OP_DIV),
      .quotient  (quot),
      .remainder (rem),
      .div_zero  (div_zero)
   );

   always_comb begin
      res_hi = hi_r;
      res_lo = lo_r;
      res_we = 1'b0;
      case (op_r)
         OP_MULT, OP_MULTU: begin
            {res_hi, res_lo} = product;
            res_we           = 1'b1;
         end
         OP_DIV, OP_DIVU: begin
            res_hi = rem;
            res_lo = quot;
            res_we = !div_zero;
         end
`ifdef MDU_MADD_EN
         OP_MADD, OP_MADDU: begin
            {res_hi, res_lo} = {hi_r, lo_r} + product;
            res_we           = 1'b1;
         end
         OP_MSUB, OP_MSUBU: begin
            {res_hi, res_lo} = {hi_r, lo_r} - product;
            res_we           = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy_r <= 1'b0;
         hi_r   <= '0;
         lo_r   <= '0;
         a_r    <= '0;
         b_r    <= '0;
         op_r   <= OP_NOP;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  if (start_mul || start_div) begin
                     op_r   <= mdu_op_e'(bus.op);
                     a_r    <= bus.a;
                     b_r    <= bus.b;
                     cnt    <= start_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
                     busy_r <= 1'b1;
                     state  <= ST_RUN;
                  end else if (bus.op == OP_MTHI) begin
                     hi_r <= bus.a;
                  end else if (bus.op == OP_MTLO) begin
                     lo_r <= bus.a;
                  end
               end
            end
            ST_RUN: begin
               // kill outranks the final-cycle commit
               if (bus.kill) begin
                  state  <= ST_IDLE;
                  cnt    <= '0;
                  busy_r <= 1'b0;
               end else if (cnt == CW'(1)) begin
                  if (res_we) begin
                     hi_r <= res_hi;
                     lo_r <= res_lo;
                  end
                  state  <= ST_IDLE;
                  cnt    <= '0;
                  busy_r <= 1'b0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state  <= ST_IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

endmodule
